// File: rtl/inst_decompressor_if.sv
// Handshake bundle between the compressed-icache side, the decompressor and
// the processor fetch path.
//   in_valid/in_ready/in_addr/in_key       : compressed word in
//   out_valid/out_ready/out_addr/out_inst/out_err : decoded instruction out
// The slave modport is the decompressor view; master is the surrounding logic.
interface inst_decompressor_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [15:0] in_key;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_inst;
    logic        out_err;

    modport slave (
        input  in_valid, in_addr, in_key, out_ready,
        output in_ready, out_valid, out_addr, out_inst, out_err
    );

    modport master (
        output in_valid, in_addr, in_key, out_ready,
        input  in_ready, out_valid, out_addr, out_inst, out_err
    );
endinterface

// File: rtl/inst_decompressor.sv
// Dictionary instruction decompressor.
// Splits each 16-bit compressed word into three keys, looks them up in three
// append-only value tables and reassembles the 32-bit RISC-V instruction.
// Two register stages (S1 key capture, S2 output register), full backpressure.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   bus (slave)         : in_* word input, out_* instruction output
//   dictN_write_enable/val, dict_clear : table load / invalidate
//   dictN_count, dict_overflow         : table fill level, sticky full-write flag
// Optional: define DECOMP_PERF_CNT_EN to add perf_inst_cnt / perf_err_cnt,
// saturating counts of delivered good / erroneous instructions.
module inst_decompressor #(
    parameter int FIELD1_KEY_WIDTH = 3,
    parameter int FIELD2_KEY_WIDTH = 8,
    parameter int FIELD3_KEY_WIDTH = 5,
    parameter int FIELD1_VAL_WIDTH = 7,
    parameter int FIELD2_VAL_WIDTH = 15,
    parameter int FIELD3_VAL_WIDTH = 10
) (
    input  logic                          clk,
    input  logic                          reset,
    inst_decompressor_if.slave            bus,
    input  logic                          dict1_write_enable,
    input  logic [FIELD1_VAL_WIDTH-1:0]   dict1_write_val,
    input  logic                          dict2_write_enable,
    input  logic [FIELD2_VAL_WIDTH-1:0]   dict2_write_val,
    input  logic                          dict3_write_enable,
    input  logic [FIELD3_VAL_WIDTH-1:0]   dict3_write_val,
    input  logic                          dict_clear,
    output logic [FIELD1_KEY_WIDTH:0]     dict1_count,
    output logic [FIELD2_KEY_WIDTH:0]     dict2_count,
    output logic [FIELD3_KEY_WIDTH:0]     dict3_count,
    output logic                          dict_overflow
`ifdef DECOMP_PERF_CNT_EN
    ,
    output logic [31:0]                   perf_inst_cnt,
    output logic [31:0]                   perf_err_cnt
`endif
);
    localparam int K1 = FIELD1_KEY_WIDTH;
    localparam int K2 = FIELD2_KEY_WIDTH;
    localparam int K3 = FIELD3_KEY_WIDTH;
    localparam int KW = K1 + K2 + K3;

    // Count value meaning "table full" (2^KEY_WIDTH)
    localparam logic [K1:0] FULL1 = {1'b1, {K1{1'b0}}};
    localparam logic [K2:0] FULL2 = {1'b1, {K2{1'b0}}};
    localparam logic [K3:0] FULL3 = {1'b1, {K3{1'b0}}};

    logic [FIELD1_VAL_WIDTH-1:0] tbl1 [2**K1];
    logic [FIELD2_VAL_WIDTH-1:0] tbl2 [2**K2];
    logic [FIELD3_VAL_WIDTH-1:0] tbl3 [2**K3];

    logic          rdy_q;
    logic          s1_valid;
    logic [KW-1:0] s1_key;
    logic [31:0]   s1_addr;

    logic          s2_take;
    logic          s1_adv;
    logic          accept;

    logic [K1-1:0] k1;
    logic [K2-1:0] k2;
    logic [K3-1:0] k3;
    logic [FIELD1_VAL_WIDTH-1:0] v1;
    logic [FIELD2_VAL_WIDTH-1:0] v2;
    logic [FIELD3_VAL_WIDTH-1:0] v3;
    logic          lk_err;
    logic [31:0]   lk_inst;

    // Table counts and overflow flag; clear beats same-cycle writes.
    always_ff @(posedge clk) begin
        if (reset || dict_clear) begin
            dict1_count   <= '0;
            dict2_count   <= '0;
            dict3_count   <= '0;
            dict_overflow <= 1'b0;
        end else begin
            if (dict1_write_enable) begin
                if (dict1_count == FULL1) dict_overflow <= 1'b1;
                else                      dict1_count   <= dict1_count + 1'b1;
            end
            if (dict2_write_enable) begin
                if (dict2_count == FULL2) dict_overflow <= 1'b1;
                else                      dict2_count   <= dict2_count + 1'b1;
            end
            if (dict3_write_enable) begin
                if (dict3_count == FULL3) dict_overflow <= 1'b1;
                else                      dict3_count   <= dict3_count + 1'b1;
            end
        end
    end

    // Table storage; contents beyond the count are never trusted, so no reset.
    always_ff @(posedge clk) begin
        if (!reset && !dict_clear) begin
            if (dict1_write_enable && dict1_count != FULL1)
                tbl1[dict1_count[K1-1:0]] <= dict1_write_val;
            if (dict2_write_enable && dict2_count != FULL2)
                tbl2[dict2_count[K2-1:0]] <= dict2_write_val;
            if (dict3_write_enable && dict3_count != FULL3)
                tbl3[dict3_count[K3-1:0]] <= dict3_write_val;
        end
    end

    // Lookup sees the registered tables/counts, so writes in the transfer
    // cycle are not visible to the word moving into S2.
    always_comb begin
        k1      = s1_key[K1-1:0];
        k2      = s1_key[K1+K2-1:K1];
        k3      = s1_key[KW-1:K1+K2];
        v1      = tbl1[k1];
        v2      = tbl2[k2];
        v3      = tbl3[k3];
        lk_err  = ({1'b0, k1} >= dict1_count) |
                  ({1'b0, k2} >= dict2_count) |
                  ({1'b0, k3} >= dict3_count);
        lk_inst = lk_err ? 32'h0 : {v3[FIELD3_VAL_WIDTH-1:3], v2[FIELD2_VAL_WIDTH-1:5],
                                    v3[2:0], v2[4:0], v1};
    end

    assign s2_take      = !bus.out_valid || bus.out_ready;
    assign s1_adv       = s1_valid && s2_take;
    // rdy_q keeps in_ready low for the first cycle out of reset.
    assign bus.in_ready = rdy_q && !reset && (!s1_valid || s1_adv);
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            rdy_q         <= 1'b0;
            s1_valid      <= 1'b0;
            s1_key        <= '0;
            s1_addr       <= '0;
            bus.out_valid <= 1'b0;
            bus.out_addr  <= '0;
            bus.out_inst  <= '0;
            bus.out_err   <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (accept) begin
                s1_valid <= 1'b1;
                s1_key   <= bus.in_key;
                s1_addr  <= bus.in_addr;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
            if (s2_take) begin
                bus.out_valid <= s1_valid;
                if (s1_valid) begin
                    bus.out_addr <= s1_addr;
                    bus.out_inst <= lk_inst;
                    bus.out_err  <= lk_err;
                end
            end
        end
    end

`ifdef DECOMP_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_inst_cnt <= '0;
            perf_err_cnt  <= '0;
        end else if (bus.out_valid && bus.out_ready) begin
            if (bus.out_err) begin
                if (perf_err_cnt != 32'hFFFF_FFFF) perf_err_cnt <= perf_err_cnt + 32'd1;
            end else begin
                if (perf_inst_cnt != 32'hFFFF_FFFF) perf_inst_cnt <= perf_inst_cnt + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_inst_decompressor.sv
module tb_inst_decompressor;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    inst_decompressor_if bus();

    logic        d1_we = 1'b0, d2_we = 1'b0, d3_we = 1'b0, dclr = 1'b0;
    logic [6:0]  d1_val = '0;
    logic [14:0] d2_val = '0;
    logic [9:0]  d3_val = '0;
    logic [3:0]  c1;
    logic [8:0]  c2;
    logic [5:0]  c3;
    logic        ovf;
`ifdef DECOMP_PERF_CNT_EN
    logic [31:0] p_inst, p_err;
    logic [31:0] mp_inst = 0, mp_err = 0;
`endif

    inst_decompressor dut (
        .clk(clk), .reset(reset), .bus(bus),
        .dict1_write_enable(d1_we), .dict1_write_val(d1_val),
        .dict2_write_enable(d2_we), .dict2_write_val(d2_val),
        .dict3_write_enable(d3_we), .dict3_write_val(d3_val),
        .dict_clear(dclr),
        .dict1_count(c1), .dict2_count(c2), .dict3_count(c3),
        .dict_overflow(ovf)
`ifdef DECOMP_PERF_CNT_EN
        , .perf_inst_cnt(p_inst), .perf_err_cnt(p_err)
`endif
    );

    // Reference model: tables as plain arrays with fill counts.
    logic [6:0]  m1 [8];
    logic [14:0] m2 [256];
    logic [9:0]  m3 [32];
    int mc1 = 0, mc2 = 0, mc3 = 0;
    bit movf = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
        logic        err;
    } exp_t;
    exp_t q[$];

    int n_cmp = 0;
    int n_err = 0;
    int since_rst = 0;
    logic [31:0] next_addr = 32'h1000;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t model_decode(input logic [15:0] key, input logic [31:0] addr);
        exp_t e;
        int a, b, c;
        a = int'(key[2:0]);
        b = int'(key[10:3]);
        c = int'(key[15:11]);
        e.addr = addr;
        e.err  = (a >= mc1) || (b >= mc2) || (c >= mc3);
        if (e.err) e.inst = 32'h0;
        else       e.inst = {m3[c][9:3], m2[b][14:5], m3[c][2:0], m2[b][4:0], m1[a]};
        return e;
    endfunction

    // Per-cycle compare process
    always @(negedge clk) begin
        if (reset) begin
            chk("in_ready_in_reset", {31'b0, bus.in_ready}, 32'd0);
            mc1 = 0; mc2 = 0; mc3 = 0; movf = 0;
            q.delete();
            since_rst = 0;
`ifdef DECOMP_PERF_CNT_EN
            mp_inst = 0; mp_err = 0;
`endif
        end else begin
            chk("dict1_count", 32'(c1), 32'(mc1));
            chk("dict2_count", 32'(c2), 32'(mc2));
            chk("dict3_count", 32'(c3), 32'(mc3));
            chk("dict_overflow", {31'b0, ovf}, {31'b0, movf});
`ifdef DECOMP_PERF_CNT_EN
            chk("perf_inst_cnt", p_inst, mp_inst);
            chk("perf_err_cnt", p_err, mp_err);
`endif
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_output: got addr %h expected no word", bus.out_addr);
                end else begin
                    chk("out_addr", bus.out_addr, q[0].addr);
                    chk("out_inst", bus.out_inst, q[0].inst);
                    chk("out_err", {31'b0, bus.out_err}, {31'b0, q[0].err});
                    if (bus.out_ready) begin
`ifdef DECOMP_PERF_CNT_EN
                        if (q[0].err) mp_err++; else mp_inst++;
`endif
                        void'(q.pop_front());
                    end
                end
            end
            // Capacity is two words: ready whenever fewer than two stay put.
            if (since_rst == 0)
                chk("in_ready_first_cycle", {31'b0, bus.in_ready}, 32'd0);
            else
                chk("in_ready", {31'b0, bus.in_ready}, {31'b0, (q.size() < 2)});
            if (dclr) begin
                mc1 = 0; mc2 = 0; mc3 = 0; movf = 0;
            end else begin
                if (d1_we) begin if (mc1 == 8)   movf = 1; else begin m1[mc1] = d1_val; mc1++; end end
                if (d2_we) begin if (mc2 == 256) movf = 1; else begin m2[mc2] = d2_val; mc2++; end end
                if (d3_we) begin if (mc3 == 32)  movf = 1; else begin m3[mc3] = d3_val; mc3++; end end
            end
            if (bus.in_valid && bus.in_ready)
                q.push_back(model_decode(bus.in_key, bus.in_addr));
            since_rst++;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] key, input logic [31:0] addr);
        bus.in_valid = 1'b1;
        bus.in_key   = key;
        bus.in_addr  = addr;
        @(negedge clk);
        chk("accept", {31'b0, bus.in_ready}, 32'd1);
        step;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input string nm);
        int b = 0;
        @(negedge clk);
        while (!bus.out_valid && b < 10) begin
            @(negedge clk);
            b++;
        end
        chk(nm, {31'b0, bus.out_valid}, 32'd1);
    endtask

    function automatic logic rdy_pat(input int mode, input int cyc);
        if (mode == 0) return !(cyc >= 3 && cyc <= 6);
        if (mode == 1) return $urandom_range(99) < 70;
        return $urandom_range(99) < 30;
    endfunction

    function automatic logic [15:0] gen_key();
        logic [2:0] a;
        logic [7:0] b;
        logic [4:0] c;
        a = 3'($urandom_range(mc1 < 8 ? mc1 : 7));
        b = 8'($urandom_range(mc2 < 256 ? mc2 : 255));
        c = 5'($urandom_range(mc3 < 32 ? mc3 : 31));
        return {c, b, a};
    endfunction

    task automatic run_stream(input int nwords, input int mode, input int vpct, output bit saw_low);
        int sent = 0, cyc = 0, budget = 200;
        logic [15:0] pk;
        logic [31:0] pa;
        saw_low = 0;
        pk = gen_key();
        pa = next_addr;
        while (sent < nwords && cyc < nwords * 20 + 50) begin
            bus.out_ready = rdy_pat(mode, cyc);
            bus.in_valid  = ($urandom_range(99) < vpct);
            bus.in_key    = pk;
            bus.in_addr   = pa;
            @(negedge clk);
            if (bus.in_valid) begin
                if (bus.in_ready) begin
                    sent++;
                    next_addr += 4;
                    pk = gen_key();
                    pa = next_addr;
                end else begin
                    saw_low = 1;
                end
            end
            step;
            cyc++;
        end
        bus.in_valid = 1'b0;
        while (q.size() > 0 && budget > 0) begin
            bus.out_ready = rdy_pat(mode, cyc);
            step;
            cyc++;
            budget--;
        end
        chk("stream_sent", sent, nwords);
        chk("stream_drain", q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        bit low;
        bus.in_valid  = 1'b0;
        bus.in_key    = '0;
        bus.in_addr   = '0;
        bus.out_ready = 1'b1;
        repeat (3) step;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("reset_out_inst", bus.out_inst, 32'd0);
        chk("reset_out_addr", bus.out_addr, 32'd0);
        step;

        // Basic decode with exact latency
        d1_we = 1; d1_val = 7'h13; d2_we = 1; d2_val = 15'h0401; d3_we = 1; d3_val = 10'h000;
        step;
        d1_we = 0; d2_we = 0; d3_we = 0;
        send(16'h0000, 32'h100);
        @(negedge clk);
        chk("basic_latency_early", {31'b0, bus.out_valid}, 32'd0);
        step;
        @(negedge clk);
        chk("basic_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("basic_inst", bus.out_inst, 32'h0010_0093);
        chk("basic_addr", bus.out_addr, 32'h100);
        chk("basic_err", {31'b0, bus.out_err}, 32'd0);
        step;

        // Invalid key (f2 key 1, count 1)
        send(16'h0008, 32'h104);
        wait_out("invalid_valid");
        chk("invalid_err", {31'b0, bus.out_err}, 32'd1);
        chk("invalid_inst", bus.out_inst, 32'd0);
        step;
        step;

        // Backpressure window
        run_stream(4, 0, 100, low);
        chk("bp_in_ready_dropped", {31'b0, low}, 32'd1);
        bus.out_ready = 1'b1;

        // Overflow
        dclr = 1; step; dclr = 0;
        for (int i = 0; i < 9; i++) begin
            d1_we = 1; d1_val = 7'(8'h40 + i);
            if (i == 0) begin d2_we = 1; d2_val = 15'h0401; d3_we = 1; d3_val = 10'h000; end
            else begin d2_we = 0; d3_we = 0; end
            step;
        end
        d1_we = 0;
        @(negedge clk);
        chk("ovf_count", 32'(c1), 32'd8);
        chk("ovf_flag", {31'b0, ovf}, 32'd1);
        step;
        send(16'h0007, 32'h200);
        wait_out("ovf_valid");
        chk("ovf_entry7", {25'b0, bus.out_inst[6:0]}, 32'h47);
        step;
        dclr = 1; step; dclr = 0;
        @(negedge clk);
        chk("clear_count", 32'(c1), 32'd0);
        chk("clear_ovf", {31'b0, ovf}, 32'd0);
        step;
        send(16'h0000, 32'h204);
        wait_out("clear_valid");
        chk("clear_err", {31'b0, bus.out_err}, 32'd1);
        step;
        step;

        // Write in the S1->S2 transfer cycle is not seen by that lookup
        d1_we = 1; d1_val = 7'h11; d2_we = 1; d2_val = 15'h0401; d3_we = 1; d3_val = 10'h000;
        step;
        d1_we = 0; d2_we = 0; d3_we = 0;
        send(16'h0001, 32'h300);
        d1_we = 1; d1_val = 7'h33;
        step;
        d1_we = 0;
        @(negedge clk);
        chk("rbw_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("rbw_err", {31'b0, bus.out_err}, 32'd1);
        chk("rbw_inst", bus.out_inst, 32'd0);
        step;
        send(16'h0001, 32'h304);
        wait_out("rbw2_valid");
        chk("rbw2_err", {31'b0, bus.out_err}, 32'd0);
        chk("rbw2_inst", {25'b0, bus.out_inst[6:0]}, 32'h33);
        step;
        step;

        // Randomized streaming against fixed tables
        dclr = 1; step; dclr = 0;
        for (int i = 0; i < 200; i++) begin
            d1_we = (i < 5);   d1_val = 7'($urandom);
            d2_we = 1'b1;      d2_val = 15'($urandom);
            d3_we = (i < 20);  d3_val = 10'($urandom);
            step;
        end
        d1_we = 0; d2_we = 0; d3_we = 0;
        run_stream(300, 1, 80, low);
        run_stream(300, 2, 90, low);
        bus.out_ready = 1'b1;

        // Reset with two words in flight
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_key    = 16'h0000;
        bus.in_addr   = 32'h400;
        step;
        bus.in_addr   = 32'h404;
        step;
        bus.in_valid  = 1'b0;
        reset = 1'b1;
        step;
        @(negedge clk);
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_count1", 32'(c1), 32'd0);
        chk("rst_count2", 32'(c2), 32'd0);
`ifdef DECOMP_PERF_CNT_EN
        chk("rst_perf_inst", p_inst, 32'd0);
        chk("rst_perf_err", p_err, 32'd0);
`endif
        step;
        reset = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) step;
        chk("final_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
